fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Pipelined, parametrised fixed-point adder/subtractor with valid/ready handshake. Each operand and the result has its own Q-format (integer bits, fraction bits, signedness). The block aligns binary points, computes the exact sum or difference, and converts it to the output format with selectable saturation or wrap-around. It is the streaming successor to the combinational `fp_add` and sits in datapaths that need back-pressure and registered timing.

## Interface
- `I1`, default 2: integer bits of `a`, sign bit included when signed.
- `F1`, default 14: fraction bits of `a`.
- `S1`, default 1: `a` is two's-complement (1) or unsigned (0).
- `I2`, `F2`, `S2`, defaults 2, 14, 1: the same for `b`.
- `I3`, `F3`, `S3`, defaults 2, 14, 1: the same for `c`.
- `SAT`, default 1: 1 = clamp to the output range, 0 = wrap (keep the low bits).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block accepts operands this cycle.
- `a` input `I1+F1`: operand A.
- `b` input `I2+F2`: operand B.
- `sub` input 1: 0 = a+b, 1 = a−b; sampled with the operands.
- `out_valid` output 1: result present.
- `out_ready` input 1: downstream accepts the result.
- `c` output `I3+F3`: result.
- `overflow` output 1: exact result exceeded the output maximum; qualified by `out_valid`.
- `underflow` output 1: exact result was below the output minimum; qualified by `out_valid`.

## Operation
- Internal format:
  - FM = max(F1,F2).
  - IM = max(I1,I2) + 2, which gives headroom for the carry and for unsigned-to-signed extension.
  - W = IM + FM.
- Stage 1, on transfer (`in_valid & in_ready`):
  - Extend each operand to W bits: sign-extend if its Sx=1, zero-extend if Sx=0.
  - Shift left by FM−Fx to align the binary points.
  - Register sum = ea + eb, or difference = ea − eb when `sub`=1, as a signed W-bit value. This result is exact and never wraps internally.
- Stage 2, output conversion:
  - If F3 < FM, drop the FM−F3 LSBs. This is arithmetic shift right, i.e. floor.
  - If F3 > FM, append F3−FM zero LSBs.
  - Output limits:
    - S3=1: max = 2^(I3+F3−1)−1, min = −2^(I3+F3−1).
    - S3=0: max = 2^(I3+F3)−1, min = 0.
  - `overflow` = value > max; `underflow` = value < min. These flags are mutually exclusive.
  - SAT=1: `c` = max on overflow, min on underflow, otherwise the value.
  - SAT=0: `c` = the low I3+F3 bits of the value. The flags are still reported.
- Handshake, with stage valids v1 and v2:
  - en2 = !v2 | out_ready.
  - en1 = !v1 | en2.
  - `in_ready` = en1, a combinational function of the state and `out_ready` only.
  - `in_ready` must not depend on `in_valid`, and `out_valid` must not depend on `out_ready`.
  - Stage 2 loads from stage 1 when en2. v2 takes v1 at that load.
  - Stage 1 loads when en1. v1 takes `in_valid` at that load.
  - `c`, `overflow` and `underflow` hold stable while `out_valid & !out_ready`.
- No reordering, drop or duplication: results emerge in acceptance order, one per accepted operand pair.

## Timing
- Latency: operands accepted at edge N produce `out_valid`=1 with the result after edge N+1 when not stalled. Both stages are registered.
- Throughput: one result per cycle while `out_ready`=1.
- Capacity: two in-flight items. With `out_ready` held low, `in_ready` falls once both stages are full.
- Reset (`rst_n`=0, asynchronous):
  - v1, v2, `out_valid`, `overflow`, `underflow` clear to 0 immediately.
  - `c` resets to 0; data registers clear.
  - `in_ready` reads 1 during and after reset.
- Reset mid-stream discards every in-flight item. The first transfer after `rst_n` deasserts behaves as from idle.
- Simultaneous output consume and input accept in the same cycle with both stages full: both pipeline stages advance and nothing is lost.
- Boundary values: a result exactly equal to max or min is not flagged.

## Test plan
- Defaults: a=0x1000 (0.25), b=0x2000 (0.5), sub=0 -> c=0x3000, no flags, `out_valid` two edges after acceptance.
- Defaults: a=0x6000, b=0x6000, sub=0 -> SAT=1 gives c=0x7FFF, overflow=1. SAT=0 gives c=0xC000, overflow=1.
- Defaults: a=0x8000 (−2.0), b=0x2000, sub=1 -> c=0x8000, underflow=1. With S3=0 and a=0x1000, b=0x2000, sub=1 -> c=0x0000, underflow=1.
- Mixed formats:
  - I1=4, F1=4, S1=0, a=0xFF (15.9375), b=0, others default -> c=0x7FFF, overflow=1.
  - F2=16, I2=0, b=0x0001 plus a=0 -> c=0x0000 (floor), no flags.
- Back-pressure: `out_ready`=0 with five back-to-back operand pairs offered -> exactly two accepted, then `in_ready`=0 and `c` is held. Release -> results appear in order with one per cycle and none lost.
- Reset: pull `rst_n` low asynchronously with two items in flight -> `out_valid`=0 at once and `in_ready`=1. After release no stale results appear, and a new pair is processed normally.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: two-stage streaming fixed-point adder/subtractor.
// Stage 1 aligns both operands to a common Q-format and registers the exact
// sum or difference; stage 2 converts it to the output Q-format with
// saturation or wrap-around and raises overflow/underflow flags.
// A valid/ready handshake runs through both stages, so the block holds at
// most two in-flight items and never drops, duplicates or reorders them.
module fp_addsub_pipe #(
  parameter int I1  = 2,
  parameter int F1  = 14,
  parameter int S1  = 1,
  parameter int I2  = 2,
  parameter int F2  = 14,
  parameter int S2  = 1,
  parameter int I3  = 2,
  parameter int F3  = 14,
  parameter int S3  = 1,
  parameter int SAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [I1+F1-1:0] a,
  input  logic [I2+F2-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [I3+F3-1:0] c,
  output logic             overflow,
  output logic             underflow
);

  // Operand and result widths.
  localparam int N1 = I1 + F1;
  localparam int N2 = I2 + F2;
  localparam int N3 = I3 + F3;

  // Internal format: common fraction width, integer part with two guard bits
  // (one for the carry, one so an unsigned operand always reads as positive).
  localparam int FM = (F1 > F2) ? F1 : F2;
  localparam int IM = ((I1 > I2) ? I1 : I2) + 2;
  localparam int W  = IM + FM;

  // Alignment shifts that bring each operand onto the FM binary point.
  localparam int SH1 = FM - F1;
  localparam int SH2 = FM - F2;

  // Output conversion: exactly one of UP/DN is non-zero (or both are zero).
  localparam int UP = (F3 >= FM) ? (F3 - FM) : 0;
  localparam int DN = (F3 <  FM) ? (FM - F3) : 0;

  // Comparison width: wide enough for the rescaled internal value and for the
  // output limits, plus margin so the limits are always positive/negative as
  // intended when compared as signed numbers.
  localparam int WV  = IM + F3;
  localparam int WC0 = (W > WV) ? W : WV;
  localparam int WC  = ((WC0 > N3) ? WC0 : N3) + 2;

  // Output range limits expressed in the comparison width.
  localparam logic signed [WC-1:0] MAX_V = (S3 != 0)
      ? {{(WC-N3+1){1'b0}}, {(N3-1){1'b1}}}
      : {{(WC-N3){1'b0}}, {N3{1'b1}}};
  localparam logic signed [WC-1:0] MIN_V = (S3 != 0)
      ? {{(WC-N3+1){1'b1}}, {(N3-1){1'b0}}}
      : {WC{1'b0}};

  // Pipeline state.
  logic                 v1_q, v1_d;
  logic                 v2_q, v2_d;
  logic signed [W-1:0]  sum_q, sum_d;
  logic [N3-1:0]        c_q, c_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;

  // Handshake enables.
  logic en1, en2;

  // Stage-1 datapath.
  logic [W-1:0]         a_ext, b_ext;
  logic [W-1:0]         ea, eb;
  logic signed [W-1:0]  sum_calc;

  // Stage-2 datapath.
  logic signed [WC-1:0] sum_wide;
  logic signed [WC-1:0] val;
  logic                 ovf_calc, udf_calc;
  logic [N3-1:0]        c_conv;

  // Stall logic: a stage may load whenever it is empty or the stage after it
  // is moving. in_ready depends only on state and out_ready.
  always_comb begin
    en2      = !v2_q || out_ready;
    en1      = !v1_q || en2;
    in_ready = en1;
  end

  // Stage-1 arithmetic: extend by signedness, align binary points, add/sub.
  // With two guard bits in W the result is exact and cannot wrap.
  always_comb begin
    a_ext    = (S1 != 0) ? {{(W-N1){a[N1-1]}}, a} : {{(W-N1){1'b0}}, a};
    b_ext    = (S2 != 0) ? {{(W-N2){b[N2-1]}}, b} : {{(W-N2){1'b0}}, b};
    ea       = a_ext << SH1;
    eb       = b_ext << SH2;
    sum_calc = sub ? (ea - eb) : (ea + eb);
  end

  // Stage-2 conversion: rescale to F3 fraction bits (floor when dropping
  // bits), range-check against the output limits, then clamp or wrap.
  always_comb begin
    sum_wide = {{(WC-W){sum_q[W-1]}}, sum_q};
    val      = (sum_wide <<< UP) >>> DN;
    ovf_calc = (val > MAX_V);
    udf_calc = (val < MIN_V);
    c_conv   = val[N3-1:0];
    if (SAT != 0) begin
      if (ovf_calc) begin
        c_conv = MAX_V[N3-1:0];
      end else if (udf_calc) begin
        c_conv = MIN_V[N3-1:0];
      end
    end
  end

  // Next-state for both stages; registers hold whenever their stage stalls,
  // which keeps c and the flags stable while out_valid & !out_ready.
  always_comb begin
    v1_d  = v1_q;
    sum_d = sum_q;
    v2_d  = v2_q;
    c_d   = c_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (en1) begin
      v1_d = in_valid;
      if (in_valid) begin
        sum_d = sum_calc;
      end
    end
    if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        c_d   = c_conv;
        ovf_d = ovf_calc;
        udf_d = udf_calc;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      sum_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      sum_q <= sum_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign out_valid = v2_q;
  assign c         = c_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: five instances with different
// formats share the handshake controls and run the same transactions.
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sub = 1'b0;
  logic out_ready = 1'b1;

  logic [15:0] a0 = '0, b0 = '0;
  logic [7:0]  a3 = '0;
  logic [15:0] b3 = '0, a4 = '0, b4 = '0;

  logic irdy0, irdy1, irdy2, irdy3, irdy4;
  logic ovld0, ovld1, ovld2, ovld3, ovld4;
  logic ovf0, ovf1, ovf2, ovf3, ovf4;
  logic udf0, udf1, udf2, udf3, udf4;
  logic [15:0] c0, c1, c2, c3, c4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // u0: all defaults (saturating)
  fp_addsub_pipe u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy0),
    .a(a0), .b(b0), .sub(sub), .out_valid(ovld0), .out_ready(out_ready),
    .c(c0), .overflow(ovf0), .underflow(udf0));
  // u1: wrap-around
  fp_addsub_pipe #(.SAT(0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy1),
    .a(a0), .b(b0), .sub(sub), .out_valid(ovld1), .out_ready(out_ready),
    .c(c1), .overflow(ovf1), .underflow(udf1));
  // u2: unsigned output
  fp_addsub_pipe #(.S3(0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy2),
    .a(a0), .b(b0), .sub(sub), .out_valid(ovld2), .out_ready(out_ready),
    .c(c2), .overflow(ovf2), .underflow(udf2));
  // u3: unsigned Q4.4 operand a
  fp_addsub_pipe #(.I1(4), .F1(4), .S1(0)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(irdy3), .a(a3), .b(b3), .sub(sub), .out_valid(ovld3), .out_ready(out_ready),
    .c(c3), .overflow(ovf3), .underflow(udf3));
  // u4: Q0.16 operand b (finer than the output)
  fp_addsub_pipe #(.I2(0), .F2(16)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(irdy4), .a(a4), .b(b4), .sub(sub), .out_valid(ovld4), .out_ready(out_ready),
    .c(c4), .overflow(ovf4), .underflow(udf4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  // One isolated transaction; returns #1 after the edge where out_valid rises.
  task automatic run_txn(input logic [15:0] ia, input logic [15:0] ib, input logic [7:0] ia3,
                         input logic [15:0] ib4, input logic isub);
    a0 = ia; b0 = ib; a3 = ia3; b3 = '0; a4 = '0; b4 = ib4; sub = isub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("in_ready_idle", 32'(irdy0), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("out_valid_after_1_edge", 32'(ovld0), 32'd0);
    @(posedge clk); #1;
    check_eq("out_valid_after_2_edges", 32'(ovld0), 32'd1);
    check_eq("out_valid_u3", 32'(ovld3), 32'd1);
  endtask

  logic [15:0] va [5];
  logic [15:0] ve [5];
  int nin, nout, first, last, nstale;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(ovld0), 32'd0);
    check_eq("rst_in_ready", 32'(irdy0), 32'd1);
    check_eq("rst_c", 32'(c0), 32'd0);
    check_eq("rst_ovf", 32'(ovf0), 32'd0);
    check_eq("rst_udf", 32'(udf0), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0.25 + 0.5; u3 15.9375 + 0; u4 0 + 2^-16 floors to 0
    run_txn(16'h1000, 16'h2000, 8'hFF, 16'h0001, 1'b0);
    check_eq("t1_u0_c", 32'(c0), 32'h3000);
    check_eq("t1_u0_ovf", 32'(ovf0), 32'd0);
    check_eq("t1_u0_udf", 32'(udf0), 32'd0);
    check_eq("t1_u1_c", 32'(c1), 32'h3000);
    check_eq("t1_u2_c", 32'(c2), 32'h3000);
    check_eq("t1_u3_c", 32'(c3), 32'h7FFF);
    check_eq("t1_u3_ovf", 32'(ovf3), 32'd1);
    check_eq("t1_u4_c", 32'(c4), 32'h0000);
    check_eq("t1_u4_flags", {30'd0, ovf4, udf4}, 32'd0);

    // 1.5 + 1.5 = 3.0
    run_txn(16'h6000, 16'h6000, 8'h00, 16'h0000, 1'b0);
    check_eq("t2_u0_c_sat", 32'(c0), 32'h7FFF);
    check_eq("t2_u0_ovf", 32'(ovf0), 32'd1);
    check_eq("t2_u1_c_wrap", 32'(c1), 32'hC000);
    check_eq("t2_u1_ovf", 32'(ovf1), 32'd1);
    check_eq("t2_u2_c", 32'(c2), 32'hC000);
    check_eq("t2_u2_ovf", 32'(ovf2), 32'd0);

    // -2.0 - 0.5 = -2.5; u4 0 - 2^-16 floors to -2^-14
    run_txn(16'h8000, 16'h2000, 8'hFF, 16'h0001, 1'b1);
    check_eq("t3_u0_c_sat", 32'(c0), 32'h8000);
    check_eq("t3_u0_udf", 32'(udf0), 32'd1);
    check_eq("t3_u0_ovf", 32'(ovf0), 32'd0);
    check_eq("t3_u1_c_wrap", 32'(c1), 32'h6000);
    check_eq("t3_u1_udf", 32'(udf1), 32'd1);
    check_eq("t3_u2_c", 32'(c2), 32'h0000);
    check_eq("t3_u2_udf", 32'(udf2), 32'd1);
    check_eq("t3_u3_c", 32'(c3), 32'h7FFF);
    check_eq("t3_u4_c_floor", 32'(c4), 32'hFFFF);
    check_eq("t3_u4_flags", {30'd0, ovf4, udf4}, 32'd0);

    // 0.25 - 0.5 = -0.25
    run_txn(16'h1000, 16'h2000, 8'h00, 16'h0000, 1'b1);
    check_eq("t4_u0_c", 32'(c0), 32'hF000);
    check_eq("t4_u0_flags", {30'd0, ovf0, udf0}, 32'd0);
    check_eq("t4_u2_c", 32'(c2), 32'h0000);
    check_eq("t4_u2_udf", 32'(udf2), 32'd1);

    // Exact signed max is not flagged
    run_txn(16'h7FFF, 16'h0000, 8'h00, 16'h0000, 1'b0);
    check_eq("t5_u0_c_max", 32'(c0), 32'h7FFF);
    check_eq("t5_u0_ovf", 32'(ovf0), 32'd0);
    check_eq("t5_u1_c", 32'(c1), 32'h7FFF);

    // Exact signed min is not flagged
    run_txn(16'h8000, 16'h0000, 8'h00, 16'h0000, 1'b0);
    check_eq("t6_u0_c_min", 32'(c0), 32'h8000);
    check_eq("t6_u0_udf", 32'(udf0), 32'd0);
    check_eq("t6_u2_udf", 32'(udf2), 32'd1);

    // 1.99994 + 1.99994: fits unsigned, overflows signed
    run_txn(16'h7FFF, 16'h7FFF, 8'h00, 16'h0000, 1'b0);
    check_eq("t7_u2_c", 32'(c2), 32'hFFFE);
    check_eq("t7_u2_ovf", 32'(ovf2), 32'd0);
    check_eq("t7_u0_ovf", 32'(ovf0), 32'd1);
    @(posedge clk); #1;

    // Back-pressure: five pairs offered while out_ready is low
    for (int k = 0; k < 5; k++) begin
      va[k] = 16'((k + 1) * 256);
      ve[k] = 16'((k + 1) * 256 + 16);
    end
    out_ready = 1'b0;
    nin = 0;
    b0 = 16'h0010; sub = 1'b0; a3 = '0; b4 = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      in_valid = 1'b1;
      a0 = va[nin];
      #1;
      if (irdy0) nin++;
      @(posedge clk); #1;
    end
    check_eq("bp_accepted", 32'(nin), 32'd2);
    check_eq("bp_in_ready_low", 32'(irdy0), 32'd0);
    check_eq("bp_out_valid", 32'(ovld0), 32'd1);
    check_eq("bp_c_held", 32'(c0), 32'(ve[0]));

    out_ready = 1'b1;
    a0 = va[nin];
    #1;
    check_eq("bp_ready_when_full_and_draining", 32'(irdy0), 32'd1);
    nout = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30 && nout < 5; cyc++) begin
      if (nin < 5) begin
        in_valid = 1'b1;
        a0 = va[nin];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (ovld0) begin
        check_eq($sformatf("bp_order_%0d", nout), 32'(c0), 32'(ve[nout]));
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      if (in_valid && irdy0) nin++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("bp_result_count", 32'(nout), 32'd5);
    check_eq("bp_one_per_cycle", 32'(last - first), 32'd4);

    // Asynchronous reset with two items in flight
    out_ready = 1'b0;
    in_valid = 1'b1; a0 = 16'h0100; b0 = 16'h0100;
    @(posedge clk); #1;
    a0 = 16'h0200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("rst2_full_in_ready", 32'(irdy0), 32'd0);
    check_eq("rst2_full_out_valid", 32'(ovld0), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst2_out_valid_async", 32'(ovld0), 32'd0);
    check_eq("rst2_in_ready_async", 32'(irdy0), 32'd1);
    check_eq("rst2_c_async", 32'(c0), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    nstale = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (ovld0) nstale++;
      @(posedge clk); #1;
    end
    check_eq("rst2_no_stale", 32'(nstale), 32'd0);
    run_txn(16'h0400, 16'h0100, 8'h00, 16'h0000, 1'b0);
    check_eq("rst2_new_c", 32'(c0), 32'h0500);
    check_eq("rst2_new_flags", {30'd0, ovf0, udf0}, 32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
